// File: rtl/encoder_input.sv
// Encoder front end: 2-flop synchronisers, per-pin debounce, quadrature detent
// decoding and button edge detection, all producing registered one-clock pulses.
module encoder_input #(
    parameter int DB_CYCLES = 12000,
    parameter int CNT_W     = 16,
    parameter int STEPS     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_a,
    input  logic key_b,
    input  logic key_ok,
    output logic L_pulse,
    output logic R_pulse,
    output logic O_pulse
);

    localparam int ACC_W = 4;
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic signed [ACC_W:0]   SAT_HI  = (ACC_W+1)'(STEPS);
    localparam logic signed [ACC_W:0]   SAT_LO  = -SAT_HI;
    localparam logic signed [ACC_W-1:0] STEPS_P = ACC_W'(STEPS);
    localparam logic signed [ACC_W-1:0] STEPS_N = -STEPS_P;

    // Channel bit order everywhere: [2] = A, [1] = B, [0] = OK.
    logic [2:0]               sync1_q, sync2_q;
    logic [2:0]               stable_q, stable_d;
    logic [CNT_W-1:0]         cnt_q [3];
    logic [CNT_W-1:0]         cnt_d [3];
    logic [1:0]               prev_ab_q;
    logic                     prev_ok_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     l_pulse_q, l_pulse_d;
    logic                     r_pulse_q, r_pulse_d;
    logic                     o_pulse_q, o_pulse_d;
    logic [1:0]               ab;
    logic signed [1:0]        step;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_sat;

    function automatic logic signed [1:0] quad_step(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b1110, 4'b1000, 4'b0001, 4'b0111: return 2'sd1;
            4'b1101, 4'b0100, 4'b0010, 4'b1011: return -2'sd1;
            default:                            return 2'sd0;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v > SAT_HI)
            return STEPS_P;
        else if (v < SAT_LO)
            return STEPS_N;
        else
            return v[ACC_W-1:0];
    endfunction

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Detent logic: the accumulator is judged and cleared on every arrival at 11;
    // an invalid jump into 11 still clears it but can never fire a pulse.
    always_comb begin
        ab        = stable_q[2:1];
        step      = quad_step(prev_ab_q, ab);
        acc_sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(step);
        acc_sat   = sat_acc(acc_sum);
        acc_d     = acc_sat;
        l_pulse_d = 1'b0;
        r_pulse_d = 1'b0;
        if (ab == 2'b11 && prev_ab_q != 2'b11) begin
            acc_d = '0;
            if (step != 2'sd0) begin
                r_pulse_d = (acc_sat == STEPS_P);
                l_pulse_d = (acc_sat == STEPS_N);
            end
        end
        o_pulse_d = prev_ok_q & ~stable_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            stable_q  <= 3'b111;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            prev_ab_q <= 2'b11;
            prev_ok_q <= 1'b1;
            acc_q     <= '0;
            l_pulse_q <= 1'b0;
            r_pulse_q <= 1'b0;
            o_pulse_q <= 1'b0;
        end else begin
            sync1_q   <= {key_a, key_b, key_ok};
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            prev_ab_q <= ab;
            prev_ok_q <= stable_q[0];
            acc_q     <= acc_d;
            l_pulse_q <= l_pulse_d;
            r_pulse_q <= r_pulse_d;
            o_pulse_q <= o_pulse_d;
        end
    end

    assign L_pulse = l_pulse_q;
    assign R_pulse = r_pulse_q;
    assign O_pulse = o_pulse_q;

endmodule

// File: doc/encoder_input.md
Name: encoder_input

Overview:
- Front-end conditioning stage for the rotary encoder (EC11-type, A/B quadrature plus push switch) on the 12 MHz board clock.
- Synchronises and debounces the raw pins, then decodes quadrature into one-cycle step pulses.
- Feeds L_pulse/R_pulse/O_pulse directly into the waveform/frequency-word control block.

Parameters:
- DB_CYCLES, 12000, clock cycles an input must stay at a new level before it is accepted (1 ms at 12 MHz); legal range 2..65535.
- CNT_W, 16, debounce counter width; must hold DB_CYCLES-1.
- STEPS, 4, valid Gray transitions per mechanical detent; legal range 1..7.

Ports:
- clk  input  1  12 MHz system clock.
- rst  input  1  Asynchronous reset, active-high. One clock domain; all flops are reset asynchronously by rst.
- key_a  input  1  Raw encoder phase A, asynchronous, idle high.
- key_b  input  1  Raw encoder phase B, asynchronous, idle high.
- key_ok  input  1  Raw push switch, asynchronous, active-low (pressed = 0).
- L_pulse  output  1  One-clk pulse per completed counter-clockwise detent.
- R_pulse  output  1  One-clk pulse per completed clockwise detent.
- O_pulse  output  1  One-clk pulse per accepted button press.

Behaviour:
- Reset values:
  - Sync flops, debounced levels and prev_ab reset to 1 (prev_ab = 2'b11).
  - Debounce counters and the signed step accumulator acc reset to 0.
  - L_pulse, R_pulse and O_pulse reset to 0.
  - Releasing rst with idle inputs produces no pulse.
- Synchroniser: a 2-flop chain on each of key_a, key_b and key_ok. No logic is placed between the two stages.
- Debounce (independent per channel, applied to the synchroniser output s):
  - If s == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Any glitch back to the stable level restarts the count.
- Latency: a raw level held constant from edge 0 updates stable at edge DB_CYCLES+2. The resulting pulse is registered and asserted at edge DB_CYCLES+3, for exactly 1 cycle.
- Quadrature decoder: operates on ab = {stable_a, stable_b} against prev_ab; prev_ab <= ab every cycle.
  - Clockwise (+1) transitions: 11->10, 10->00, 00->01, 01->11.
  - Counter-clockwise (-1) transitions: 11->01, 01->00, 00->10, 10->11.
  - No change: acc unchanged.
  - Both bits changing in one cycle (invalid): acc unchanged, no pulse.
  - acc saturates at +STEPS and -STEPS and never wraps.
- Detent evaluation, on the cycle a transition lands on ab = 11:
  - If the updated acc == +STEPS: R_pulse = 1 next cycle.
  - If the updated acc == -STEPS: L_pulse = 1 next cycle.
  - acc is cleared to 0 on every arrival at 11, whether or not a pulse is issued.
  - Partial turns and reversals before the detent produce no pulse.
- L_pulse and R_pulse are mutually exclusive by construction.
- Button: O_pulse = 1 for one cycle on a debounced 1->0 transition of key_ok. Release (0->1) produces nothing. Holding the button produces no repeats.
- Simultaneous events: O_pulse may coincide with L_pulse or R_pulse. Both are driven and the consumer resolves priority.
- Reset mid-operation: all state returns to reset values immediately. Any in-progress debounce or partial rotation is discarded. If a pin is held low through reset release, it is re-accepted after DB_CYCLES and may then produce a pulse.
- Outputs are registered. No combinational path exists from inputs to outputs.

Test Plan (DB_CYCLES=4, STEPS=4):
- Reset release, all inputs high, run 100 cycles -> L_pulse, R_pulse and O_pulse stay 0 throughout.
- AB sequence 11,10,00,01,11, each level held 10 cycles -> exactly one R_pulse, 1 cycle wide, 7 cycles after the final raw change to 11; L_pulse stays 0.
- AB sequence 11,01,00,10,11 -> exactly one L_pulse. Sequence 11,10,00,10,11 (reversal) -> no pulse, and acc is 0 afterwards.
- key_a toggled every 2 cycles for 40 cycles (bounce), then settles high -> stable_a never changes and no pulse occurs. key_ok low for 3 cycles -> no O_pulse; low for 20 cycles -> one O_pulse at cycle 7; release -> none.
- Press key_ok and complete a clockwise detent so both are accepted in the same cycle -> O_pulse and R_pulse asserted together for 1 cycle.
- Assert rst for 1 cycle midway through a clockwise sequence (at ab = 00), then finish the sequence -> no R_pulse for that detent; the next full clockwise detent -> one R_pulse.
